operation_sequencer: RTL

OPERATION_SEQUENCER -- requirements
Module: operation_sequencer

---
 rtl/operation_sequencer_pkg.sv | 43 ++++
 rtl/operation_sequencer_seq_multiplier.sv | 59 +++++
 rtl/operation_sequencer.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/operation_sequencer_pkg.sv
// Shared definitions for the operation sequencer: widths, instruction field
// positions, opcode and FSM state encodings.
package operation_sequencer_pkg;

  localparam int DATA_WIDTH_DEF = 16;
  localparam int ADDR_WIDTH_DEF = 6;
  localparam int INSTR_WIDTH    = 16;

  // Instruction layout: opcode | RegA (dest + first source) | RegB
  localparam int OPC_MSB  = 15;
  localparam int OPC_LSB  = 12;
  localparam int REGA_MSB = 11;
  localparam int REGA_LSB = 6;
  localparam int REGB_MSB = 5;
  localparam int REGB_LSB = 0;

  typedef enum logic [3:0] {
    OP_NOP = 4'd0,
    OP_ADD = 4'd1,
    OP_SUB = 4'd2,
    OP_AND = 4'd3,
    OP_OR  = 4'd4,
    OP_XOR = 4'd5,
    OP_SHL = 4'd6,
    OP_SHR = 4'd7,
    OP_MUL = 4'd8,
    OP_MOV = 4'd9
  } opcode_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_EXEC  = 3'd2,
    ST_MUL   = 3'd3,
    ST_WRITE = 3'd4
  } state_e;

  // Opcodes 1..9 produce a result; 0 and the reserved 10..15 behave as NOP.
  function automatic logic op_writes(input logic [3:0] op);
    return (op != 4'(OP_NOP)) && (op <= 4'(OP_MOV));
  endfunction

endpackage

// File: rtl/operation_sequencer_seq_multiplier.sv
// Radix-2 shift-add multiplier, one multiplier bit retired per cycle.
// o_product shows the accumulator including the bit being retired this
// cycle, so on the o_last cycle it already carries the final product.
module seq_multiplier
  import operation_sequencer_pkg::*;
#(
  parameter int WIDTH = DATA_WIDTH_DEF
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_start,
  input  logic [WIDTH-1:0]   i_mcand,
  input  logic [WIDTH-1:0]   i_mplier,
  output logic               o_busy,
  output logic               o_last,
  output logic [2*WIDTH-1:0] o_product
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  logic [2*WIDTH-1:0] r_mcand;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_mplier;
  logic [CNT_W-1:0]   r_cnt;
  logic [2*WIDTH-1:0] w_acc_next;

  // Add the shifted multiplicand when the current multiplier bit is set.
  always_comb begin
    w_acc_next = r_acc;
    if (r_mplier[0]) begin
      w_acc_next = r_acc + r_mcand;
    end
  end

  assign o_busy    = (r_cnt != '0);
  assign o_last    = (r_cnt == CNT_W'(1));
  assign o_product = w_acc_next;

  // Load operands on start, then shift one bit per cycle until the count expires.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_mcand  <= '0;
      r_acc    <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
    end else if (i_start) begin
      r_mcand  <= {{WIDTH{1'b0}}, i_mcand};
      r_mplier <= i_mplier;
      r_acc    <= '0;
      r_cnt    <= CNT_W'(WIDTH);
    end else if (o_busy) begin
      r_acc    <= w_acc_next;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt - CNT_W'(1);
    end
  end

endmodule

// File: rtl/operation_sequencer.sv
// Single-issue instruction sequencer driving a two-port register file.
//
//   state | meaning
//   IDLE  | ready for an instruction, addresses hold last value
//   READ  | register file addressed, operands captured at end of cycle
//   EXEC  | ALU result formed; MUL kicks off the shift-add multiplier
//   MUL   | 16 multiplier cycles, one bit each
//   WRITE | result written (unless NOP/reserved), Done pulses
module operation_sequencer
  import operation_sequencer_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic                   i_Clock,
  input  logic                   i_nReset,
  input  logic                   i_InstrValid,
  output logic                   o_InstrReady,
  input  logic [INSTR_WIDTH-1:0] i_Instr,
  output logic [ADDR_WIDTH-1:0]  o_AddressA,
  output logic [ADDR_WIDTH-1:0]  o_AddressB,
  input  logic [DATA_WIDTH-1:0]  i_ReadDataA,
  input  logic [DATA_WIDTH-1:0]  i_ReadDataB,
  output logic [DATA_WIDTH-1:0]  o_WriteData,
  output logic                   o_WriteEnable,
  output logic                   o_Done,
  output logic                   o_Zero,
  output logic                   o_Carry
);

  state_e                  r_state;
  logic [3:0]              r_opcode;
  logic [ADDR_WIDTH-1:0]   r_addr_a;
  logic [ADDR_WIDTH-1:0]   r_addr_b;
  logic [DATA_WIDTH-1:0]   r_op_a;
  logic [DATA_WIDTH-1:0]   r_op_b;
  logic                    r_ready;
  logic                    r_we;
  logic                    r_done;
  logic [DATA_WIDTH-1:0]   r_wdata;
  logic                    r_zero;
  logic                    r_carry;

  logic [DATA_WIDTH:0]     w_sum;
  logic [DATA_WIDTH-1:0]   w_alu_result;
  logic                    w_alu_carry;
  logic                    w_mul_start;
  logic                    w_mul_busy;
  logic                    w_mul_last;
  logic [2*DATA_WIDTH-1:0] w_mul_product;
  logic [DATA_WIDTH-1:0]   w_mul_low;
  logic                    w_mul_carry;

  assign w_mul_start = (r_state == ST_EXEC) && (r_opcode == OP_MUL);
  assign w_mul_low   = w_mul_product[DATA_WIDTH-1:0];
  assign w_mul_carry = |w_mul_product[2*DATA_WIDTH-1:DATA_WIDTH];
  assign w_sum       = {1'b0, r_op_a} + {1'b0, r_op_b};

  seq_multiplier #(
    .WIDTH (DATA_WIDTH)
  ) u_mul (
    .i_clk     (i_Clock),
    .i_rst_n   (i_nReset),
    .i_start   (w_mul_start),
    .i_mcand   (r_op_a),
    .i_mplier  (r_op_b),
    .o_busy    (w_mul_busy),
    .o_last    (w_mul_last),
    .o_product (w_mul_product)
  );

  // Single-cycle ALU for every opcode except MUL; carry defaults to its held value.
  always_comb begin
    w_alu_result = '0;
    w_alu_carry  = r_carry;
    case (r_opcode)
      OP_ADD: begin
        w_alu_result = w_sum[DATA_WIDTH-1:0];
        w_alu_carry  = w_sum[DATA_WIDTH];
      end
      OP_SUB: begin
        w_alu_result = r_op_a - r_op_b;
        w_alu_carry  = (r_op_a < r_op_b);
      end
      OP_AND:  w_alu_result = r_op_a & r_op_b;
      OP_OR:   w_alu_result = r_op_a | r_op_b;
      OP_XOR:  w_alu_result = r_op_a ^ r_op_b;
      OP_SHL:  w_alu_result = r_op_a << r_op_b[3:0];
      OP_SHR:  w_alu_result = r_op_a >> r_op_b[3:0];
      OP_MOV:  w_alu_result = r_op_b;
      default: ;
    endcase
  end

  // Sequencer FSM with registered handshake, write strobe, result and flags.
  always_ff @(posedge i_Clock or negedge i_nReset) begin
    if (!i_nReset) begin
      r_state  <= ST_IDLE;
      r_opcode <= OP_NOP;
      r_addr_a <= '0;
      r_addr_b <= '0;
      r_op_a   <= '0;
      r_op_b   <= '0;
      r_ready  <= 1'b1;
      r_we     <= 1'b0;
      r_done   <= 1'b0;
      r_wdata  <= '0;
      r_zero   <= 1'b0;
      r_carry  <= 1'b0;
    end else begin
      r_we   <= 1'b0;
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (i_InstrValid) begin
            r_opcode <= i_Instr[OPC_MSB:OPC_LSB];
            r_addr_a <= i_Instr[REGA_MSB:REGA_LSB];
            r_addr_b <= i_Instr[REGB_MSB:REGB_LSB];
            r_ready  <= 1'b0;
            r_state  <= ST_READ;
          end
        end
        ST_READ: begin
          r_op_a  <= i_ReadDataA;
          r_op_b  <= i_ReadDataB;
          r_state <= ST_EXEC;
        end
        ST_EXEC: begin
          if (r_opcode == OP_MUL) begin
            r_state <= ST_MUL;
          end else begin
            r_state <= ST_WRITE;
            r_done  <= 1'b1;
            if (op_writes(r_opcode)) begin
              r_we    <= 1'b1;
              r_wdata <= w_alu_result;
              r_zero  <= (w_alu_result == '0);
              r_carry <= w_alu_carry;
            end
          end
        end
        ST_MUL: begin
          // o_product already includes the final bit on the last cycle.
          if (w_mul_last || !w_mul_busy) begin
            r_state <= ST_WRITE;
            r_done  <= 1'b1;
            r_we    <= 1'b1;
            r_wdata <= w_mul_low;
            r_zero  <= (w_mul_low == '0);
            r_carry <= w_mul_carry;
          end
        end
        ST_WRITE: begin
          r_state <= ST_IDLE;
          r_ready <= 1'b1;
        end
        default: begin
          r_state <= ST_IDLE;
          r_ready <= 1'b1;
        end
      endcase
    end
  end

  assign o_InstrReady  = r_ready;
  assign o_AddressA    = r_addr_a;
  assign o_AddressB    = r_addr_b;
  assign o_WriteData   = r_wdata;
  assign o_WriteEnable = r_we;
  assign o_Done        = r_done;
  assign o_Zero        = r_zero;
  assign o_Carry       = r_carry;

endmodule
